io_led_switch: RTL and testbench
================================

IO_LED_SWITCH -- requirements
Module: io_led_switch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 20000: clock cycles per debounce sample tick; legal range 2 or more.
REQ-002 SHALL have port clock, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port LEDCtrl, input, 1: LED chip select, driven by the IO-write strobe of the memory/IO mux.
REQ-005 SHALL have port SwitchCtrl, input, 1: switch chip select, driven by the IO-read strobe of the memory/IO mux.
REQ-006 SHALL have port io_addr, input, 8: low byte of the IO address (addr_out[7:0]).
REQ-007 SHALL have port io_wdata, input, 16: write data (write_data[15:0]).
REQ-008 SHALL have port switch_i, input, 24: raw asynchronous board switches.
REQ-009 SHALL have port led_o, output, 24: board LEDs.
REQ-010 SHALL have port io_rdata, output, 16: read data returned to the memory/IO mux.

Function
REQ-011 SHALL update led_o[15:0] <= io_wdata on a rising edge with LEDCtrl=1 and io_addr=8'h60.
REQ-012 SHALL update led_o[23:16] <= io_wdata[7:0] on a rising edge with LEDCtrl=1 and io_addr=8'h62.
REQ-013 SHALL ignore writes to any other io_addr, and SHALL hold led_o whenever LEDCtrl=0.
REQ-014 SHALL pass switch_i through a 2-flop synchronizer per bit, giving sync[23:0] with 2-cycle latency.
REQ-015 SHALL run a tick counter 0..TICK_DIV-1 that wraps to 0; tick=1 in the cycle the counter equals TICK_DIV-1.
REQ-016 SHALL, on each tick edge, shift sync into a 3-deep per-bit sample history (newest, mid, oldest).
REQ-017 SHALL, on that same tick edge, set debounced bit <= v when the new sample and the two previously stored samples all equal v; otherwise the bit holds.
REQ-018 SHALL not reflect a pulse shorter than 3 consecutive ticks in debounced.
REQ-019 SHALL set the sticky changed flag on any edge where debounced takes a new value.
REQ-020 SHALL make io_rdata combinational, qualified by SwitchCtrl=1:
- io_addr 8'h70: debounced[15:0]
- io_addr 8'h72: {8'h00, debounced[23:16]}
- io_addr 8'h74: {15'b0, changed}
- other addresses: 16'h0000
REQ-021 SHALL drive io_rdata = 16'h0000 when SwitchCtrl=0.
REQ-022 SHALL clear changed on a rising edge with SwitchCtrl=1 and io_addr=8'h74 (read-to-clear); the read in that cycle returns the pre-clear value.
REQ-023 SHALL leave changed at 1 when a set (REQ-019) and a clear (REQ-022) occur on the same edge (set wins).
REQ-024 SHALL let LEDCtrl and SwitchCtrl act independently if both are asserted in one cycle.

Reset
REQ-025 SHALL, on an edge with reset=1, clear led_o, both synchronizer stages, sample history, debounced, changed and the tick counter to 0; reset overrides all writes and clears.
REQ-026 SHALL, after reset, accept switches already high as new debounced values after 3 ticks, and SHALL set changed when it does.
REQ-027 SHALL make reset mid-debounce discard partial sample history.

Verification (TICK_DIV=4)
REQ-028 SHALL cover: reset, then LEDCtrl=1, io_addr=60, io_wdata=A5A5; next cycle io_addr=62, io_wdata=00C3 -> led_o=24'hC3A5A5; a write at io_addr=64 leaves led_o unchanged.
REQ-029 SHALL cover: switch_i=24'h00F00F held for 20 cycles -> debounced=00F00F; read at 70 returns F00F, at 72 returns 0000, at 74 returns 0001.
REQ-030 SHALL cover: read at 74 (clear edge) -> a later read at 74 returns 0000; a clear coinciding with a debounced change -> changed stays 1.
REQ-031 SHALL cover: a switch_i[0] glitch high for 6 cycles (under 3 ticks) -> debounced[0] stays 0 and changed stays 0.
REQ-032 SHALL cover: SwitchCtrl=0 with io_addr=70 -> io_rdata=0000.
REQ-033 SHALL cover: reset asserted after 2 stable ticks -> debounced=0 and led_o=0, and 3 further ticks are required before debounced updates.

Source files
------------

// File: rtl/io_led_switch.sv
// LED output register and debounced switch input port for the memory/IO mux.
// LEDs are written at 0x60/0x62; debounced switches and a sticky changed flag are read at 0x70/0x72/0x74.
module io_led_switch #(
    parameter int unsigned TICK_DIV = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        LEDCtrl,
    input  logic        SwitchCtrl,
    input  logic [7:0]  io_addr,
    input  logic [15:0] io_wdata,
    input  logic [23:0] switch_i,
    output logic [23:0] led_o,
    output logic [15:0] io_rdata
);

    localparam int unsigned SW_W  = 24;
    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [7:0] ADDR_LED_LO = 8'h60;
    localparam logic [7:0] ADDR_LED_HI = 8'h62;
    localparam logic [7:0] ADDR_SW_LO  = 8'h70;
    localparam logic [7:0] ADDR_SW_HI  = 8'h72;
    localparam logic [7:0] ADDR_SW_CHG = 8'h74;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [SW_W-1:0]  sync_a;
    logic [SW_W-1:0]  sync_b;
    logic [SW_W-1:0]  hist_new;
    logic [SW_W-1:0]  hist_mid;
    logic [SW_W-1:0]  debounced;
    logic [SW_W-1:0]  deb_next;
    logic [SW_W-1:0]  all_one;
    logic [SW_W-1:0]  all_zero;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             changed;
    logic             chg_set;
    logic             chg_clr;

    assign tick = (tick_cnt == CNT_LAST);

    // The sample being shifted in plus the two stored ones form the 3-deep window.
    always_comb begin
        all_one  = sync_b & hist_new & hist_mid;
        all_zero = ~(sync_b | hist_new | hist_mid);
        deb_next = (debounced | all_one) & ~all_zero;
        chg_set  = tick && (deb_next != debounced);
        chg_clr  = SwitchCtrl && (io_addr == ADDR_SW_CHG);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            tick_cnt <= '0;
        end else begin
            sync_a   <= switch_i;
            sync_b   <= sync_a;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_new  <= '0;
            hist_mid  <= '0;
            debounced <= '0;
        end else if (tick) begin
            hist_new  <= sync_b;
            hist_mid  <= hist_new;
            debounced <= deb_next;
        end
    end

    // Set wins over a read-to-clear on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            changed <= 1'b0;
        end else if (chg_set) begin
            changed <= 1'b1;
        end else if (chg_clr) begin
            changed <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_o <= '0;
        end else if (LEDCtrl) begin
            if (io_addr == ADDR_LED_LO) begin
                led_o[15:0] <= io_wdata;
            end
            if (io_addr == ADDR_LED_HI) begin
                led_o[23:16] <= io_wdata[7:0];
            end
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (SwitchCtrl) begin
            case (io_addr)
                ADDR_SW_LO:  io_rdata = debounced[15:0];
                ADDR_SW_HI:  io_rdata = {8'h00, debounced[23:16]};
                ADDR_SW_CHG: io_rdata = {15'b0, changed};
                default:     io_rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_io_led_switch.sv
// Bench for io_led_switch: directed scenarios then randomized traffic, checked against a
// sample-queue model of the LED register, debouncer and changed flag.
module tb_io_led_switch;

    localparam int unsigned DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        LEDCtrl = 1'b0;
    logic        SwitchCtrl = 1'b0;
    logic [7:0]  io_addr = 8'h00;
    logic [15:0] io_wdata = 16'h0000;
    logic [23:0] switch_i = 24'h0;
    logic [23:0] led_o;
    logic [15:0] io_rdata;

    int tests = 0;
    int fails = 0;

    io_led_switch #(.TICK_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .LEDCtrl(LEDCtrl), .SwitchCtrl(SwitchCtrl),
        .io_addr(io_addr), .io_wdata(io_wdata), .switch_i(switch_i),
        .led_o(led_o), .io_rdata(io_rdata)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [23:0] m_led, m_s1, m_s2, m_deb;
    logic [23:0] m_samp[$];
    int          m_cnt;
    bit          m_chg;

    task automatic model_reset();
        m_led = '0; m_s1 = '0; m_s2 = '0; m_deb = '0;
        m_samp = {24'h0, 24'h0, 24'h0};
        m_cnt = 0; m_chg = 0;
    endtask

    function automatic logic [15:0] model_rdata();
        if (!SwitchCtrl) return 16'h0000;
        case (io_addr)
            8'h70:   return m_deb[15:0];
            8'h72:   return {8'h00, m_deb[23:16]};
            8'h74:   return {15'b0, m_chg};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [23:0] old_deb;
        bit tick;
        if (reset) begin
            model_reset();
            return;
        end
        old_deb = m_deb;
        tick = (m_cnt == DIV - 1);
        if (tick) begin
            m_samp.push_back(m_s2);
            while (m_samp.size() > 3) void'(m_samp.pop_front());
            for (int b = 0; b < 24; b++) begin
                int ones = 0;
                foreach (m_samp[k]) ones += int'(m_samp[k][b]);
                if (ones == 3) m_deb[b] = 1'b1;
                else if (ones == 0) m_deb[b] = 1'b0;
            end
        end
        if (m_deb != old_deb) m_chg = 1;
        else if (SwitchCtrl && io_addr == 8'h74) m_chg = 0;
        if (LEDCtrl && io_addr == 8'h60) m_led[15:0] = io_wdata;
        if (LEDCtrl && io_addr == 8'h62) m_led[23:16] = io_wdata[7:0];
        m_s2 = m_s1;
        m_s1 = switch_i;
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational read, take the edge, check registered LEDs.
    task automatic step();
        #1;
        chk("rdata", 24'(io_rdata), 24'(model_rdata()));
        @(posedge clock);
        model_edge();
        #1;
        chk("led", led_o, m_led);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [7:0] a);
        LEDCtrl = 0; SwitchCtrl = 1; io_addr = a;
        #1;
    endtask

    bit saw_one;

    initial begin
        model_reset();
        @(negedge clock);
        reset = 1;
        idle(2);
        reset = 0;

        // Reset state
        rd(8'h74); chk("rst_chg", 24'(io_rdata), 24'h0);
        chk("rst_led", led_o, 24'h0);
        SwitchCtrl = 0;

        // LED writes
        LEDCtrl = 1; io_addr = 8'h60; io_wdata = 16'hA5A5; step();
        io_addr = 8'h62; io_wdata = 16'h00C3; step();
        chk("led_c3a5a5", led_o, 24'hC3A5A5);
        io_addr = 8'h64; io_wdata = 16'h1234; step();
        chk("led_hold_64", led_o, 24'hC3A5A5);
        LEDCtrl = 0; io_addr = 8'h60; io_wdata = 16'hFFFF; step();
        chk("led_hold_nocs", led_o, 24'hC3A5A5);

        // Stable switches debounce through
        switch_i = 24'h00F00F;
        idle(20);
        rd(8'h70); chk("sw_lo", 24'(io_rdata), 24'h00F00F);
        rd(8'h72); chk("sw_hi", 24'(io_rdata), 24'h0);
        SwitchCtrl = 0; io_addr = 8'h70; #1;
        chk("nocs_read", 24'(io_rdata), 24'h0);
        rd(8'h74); chk("chg_set", 24'(io_rdata), 24'h1);
        step();
        rd(8'h74); chk("chg_cleared", 24'(io_rdata), 24'h0);

        // Clear held across a debounced change: set wins, so a 1 must be seen
        switch_i = 24'h0; saw_one = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (io_rdata == 16'h0001) saw_one = 1;
        end
        chk("set_wins", 24'(saw_one), 24'h1);
        rd(8'h70); chk("sw_zero", 24'(io_rdata), 24'h0);
        rd(8'h74); chk("chg_after", 24'(io_rdata), 24'h0);
        SwitchCtrl = 0;

        // Short glitch on bit 0
        switch_i = 24'h000001; idle(6);
        switch_i = 24'h0; idle(20);
        rd(8'h70); chk("glitch_deb", 24'(io_rdata), 24'h0);
        rd(8'h74); chk("glitch_chg", 24'(io_rdata), 24'h0);
        SwitchCtrl = 0;

        // Reset after two stable ticks discards history
        reset = 1; step(); reset = 0;
        switch_i = 24'hFFFFFF; idle(9);
        reset = 1; step(); reset = 0;
        rd(8'h70); chk("mid_rst_deb", 24'(io_rdata), 24'h0);
        chk("mid_rst_led", led_o, 24'h0);
        SwitchCtrl = 0;
        idle(11);
        rd(8'h70); chk("pre_third_tick", 24'(io_rdata), 24'h0);
        SwitchCtrl = 0; step();
        rd(8'h70); chk("third_tick_lo", 24'(io_rdata), 24'h00FFFF);
        rd(8'h72); chk("third_tick_hi", 24'(io_rdata), 24'h0000FF);
        rd(8'h74); chk("third_tick_chg", 24'(io_rdata), 24'h1);
        step();

        // Randomized traffic
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            if ($urandom_range(0, 1) == 1) switch_i = switch_i ^ (24'h1 << $urandom_range(0, 23));
            else switch_i = 24'($urandom());
            hold = $urandom_range(1, 16);
            for (int c = 0; c < hold; c++) begin
                logic [7:0] addrs[7];
                addrs = '{8'h60, 8'h62, 8'h64, 8'h70, 8'h72, 8'h74, 8'h00};
                addrs[6] = 8'($urandom());
                reset = ($urandom_range(0, 99) == 0);
                LEDCtrl = 1'($urandom_range(0, 1));
                SwitchCtrl = 1'($urandom_range(0, 1));
                io_addr = addrs[$urandom_range(0, 6)];
                io_wdata = 16'($urandom());
                step();
            end
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
